// File: rtl/render_scheduler_if.sv
// Bundle between VGA timing / game state and the sprite scheduler.
// Slave side is the scheduler; master side drives positions and timing.
interface render_scheduler_if #(
  parameter int MAX_SEGMENTS = 23,
  parameter int ADDR_W       = 10
);
  logic                      line_start;
  logic [10:0]               next_y;
  logic                      de;
  logic [10:0]               curr_x;
  logic [11*MAX_SEGMENTS-1:0] snakepos_x;
  logic [11*MAX_SEGMENTS-1:0] snakepos_y;
  logic [5:0]                length;
  logic [10:0]               applepos_x;
  logic [10:0]               applepos_y;
  logic                      game_end;
  logic [1:0]                sel;
  logic                      sel_valid;
  logic [ADDR_W-1:0]         sprite_addr;
  logic                      scan_busy;

  modport master (
    output line_start, next_y, de, curr_x,
    output snakepos_x, snakepos_y, length,
    output applepos_x, applepos_y, game_end,
    input  sel, sel_valid, sprite_addr, scan_busy
  );

  modport slave (
    input  line_start, next_y, de, curr_x,
    input  snakepos_x, snakepos_y, length,
    input  applepos_x, applepos_y, game_end,
    output sel, sel_valid, sprite_addr, scan_busy
  );
endinterface

// File: rtl/render_scheduler.sv
// Snake renderer scheduler: per-line row pre-scan in hblank,
// per-pixel layer select and sprite-local ROM address.
module render_scheduler #(
  parameter int MAX_SEGMENTS = 23,
  parameter int BLK_SIZE     = 32,
  parameter int ADDR_W       = 10
) (
  input  logic               clk,
  input  logic               rst,
  render_scheduler_if.slave  bus
);

  localparam int DW = $clog2(BLK_SIZE);
  localparam int IW = $clog2(MAX_SEGMENTS);
  localparam logic [IW-1:0] LAST = IW'(MAX_SEGMENTS - 1);
  localparam logic [10:0]   BLK  = 11'(BLK_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_t;

  state_t                         state_q, state_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [10:0]                    line_y_q, line_y_d;
  logic [MAX_SEGMENTS-1:0]        sh_mask_q, sh_mask_d;
  logic [MAX_SEGMENTS-1:0][DW-1:0] sh_dy_q, sh_dy_d;
  logic                           sh_apple_q, sh_apple_d;
  logic [DW-1:0]                  sh_ady_q, sh_ady_d;
  logic [MAX_SEGMENTS-1:0]        act_mask_q, act_mask_d;
  logic [MAX_SEGMENTS-1:0][DW-1:0] act_dy_q, act_dy_d;
  logic                           act_apple_q, act_apple_d;
  logic [DW-1:0]                  act_ady_q, act_ady_d;
  logic [1:0]                     sel_q, sel_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic                           vld_q;

  logic [10:0] ady;
  logic [10:0] sy_cur;
  logic [10:0] sdy;
  logic        slot_hit;

  always_comb begin
    ady      = bus.next_y - bus.applepos_y;
    sy_cur   = bus.snakepos_y[11*int'(idx_q) +: 11];
    sdy      = line_y_q - sy_cur;
    slot_hit = (32'(idx_q) < 32'(bus.length)) && (sdy < BLK);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    line_y_d    = line_y_q;
    sh_mask_d   = sh_mask_q;
    sh_dy_d     = sh_dy_q;
    sh_apple_d  = sh_apple_q;
    sh_ady_d    = sh_ady_q;
    act_mask_d  = act_mask_q;
    act_dy_d    = act_dy_q;
    act_apple_d = act_apple_q;
    act_ady_d   = act_ady_q;
    // A new line_start always wins, aborting any scan in flight
    if (bus.line_start) begin
      state_d    = SCAN;
      idx_d      = '0;
      line_y_d   = bus.next_y;
      sh_apple_d = ady < BLK;
      sh_ady_d   = ady[DW-1:0];
    end else begin
      unique case (state_q)
        IDLE: ;
        SCAN: begin
          sh_mask_d[idx_q] = slot_hit;
          sh_dy_d[idx_q]   = sdy[DW-1:0];
          if (idx_q == LAST) state_d = COMMIT;
          else               idx_d   = idx_q + 1'b1;
        end
        COMMIT: begin
          act_mask_d  = sh_mask_q;
          act_dy_d    = sh_dy_q;
          act_apple_d = sh_apple_q;
          act_ady_d   = sh_ady_q;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic [10:0]   dxa, dxh, bx;
  logic          a_hit, h_hit, b_hit;
  logic [DW-1:0] b_dx, b_dy;

  always_comb begin
    dxa   = bus.curr_x - bus.applepos_x;
    dxh   = bus.curr_x - bus.snakepos_x[10:0];
    a_hit = act_apple_q && (dxa < BLK);
    h_hit = act_mask_q[0] && (dxh < BLK);
    b_hit = 1'b0;
    b_dx  = '0;
    b_dy  = '0;
    bx    = '0;
    // Descending walk so the lowest hitting slot is the one left standing
    for (int i = MAX_SEGMENTS - 1; i >= 1; i--) begin
      bx = bus.curr_x - bus.snakepos_x[11*i +: 11];
      if (act_mask_q[i] && (bx < BLK)) begin
        b_hit = 1'b1;
        b_dx  = bx[DW-1:0];
        b_dy  = act_dy_q[i];
      end
    end
    sel_d  = 2'd0;
    addr_d = '0;
    if (bus.de && !bus.game_end) begin
      priority case (1'b1)
        a_hit: begin
          sel_d  = 2'd1;
          addr_d = ADDR_W'({act_ady_q, dxa[DW-1:0]});
        end
        h_hit: begin
          sel_d  = 2'd2;
          addr_d = ADDR_W'({act_dy_q[0], dxh[DW-1:0]});
        end
        b_hit: begin
          sel_d  = 2'd3;
          addr_d = ADDR_W'({b_dy, b_dx});
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      line_y_q    <= '0;
      sh_mask_q   <= '0;
      sh_dy_q     <= '0;
      sh_apple_q  <= 1'b0;
      sh_ady_q    <= '0;
      act_mask_q  <= '0;
      act_dy_q    <= '0;
      act_apple_q <= 1'b0;
      act_ady_q   <= '0;
      sel_q       <= 2'd0;
      addr_q      <= '0;
      vld_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      line_y_q    <= line_y_d;
      sh_mask_q   <= sh_mask_d;
      sh_dy_q     <= sh_dy_d;
      sh_apple_q  <= sh_apple_d;
      sh_ady_q    <= sh_ady_d;
      act_mask_q  <= act_mask_d;
      act_dy_q    <= act_dy_d;
      act_apple_q <= act_apple_d;
      act_ady_q   <= act_ady_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      vld_q       <= bus.de;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.sprite_addr = addr_q;
  assign bus.sel_valid   = vld_q;
  assign bus.scan_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_render_scheduler.sv
// Self-checking bench for render_scheduler: directed cases plus
// randomized lines/pixels against a modulo-2048 geometry model.
module tb_render_scheduler;

  localparam int NS = 23;

  logic clk = 1'b0;
  logic rst = 1'b0;

  render_scheduler_if #(.MAX_SEGMENTS(NS), .ADDR_W(10)) bus ();

  render_scheduler #(
    .MAX_SEGMENTS(NS),
    .BLK_SIZE(32),
    .ADDR_W(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int sx[NS], sy[NS];
  int len, ax, ay;
  int p_y, p_len, p_ay;
  int p_sy[NS];
  bit act_ok = 1'b0;
  int act_y, act_len, act_ay;
  int act_sy[NS];
  int obs_sel, obs_addr;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int md(input int v);
    return ((v % 2048) + 2048) % 2048;
  endfunction

  task automatic model(input int x, input bit de, input bit ge,
                       output int es, output int ea);
    int n, dy, dx;
    es = 0;
    ea = 0;
    if (!de || ge || !act_ok) return;
    dy = md(act_y - act_ay);
    dx = md(x - ax);
    if (dy < 32 && dx < 32) begin
      es = 1;
      ea = dy * 32 + dx;
      return;
    end
    n = (act_len > NS) ? NS : act_len;
    for (int i = 0; i < n; i++) begin
      dy = md(act_y - act_sy[i]);
      dx = md(x - sx[i]);
      if (dy < 32 && dx < 32) begin
        es = (i == 0) ? 2 : 3;
        ea = dy * 32 + dx;
        return;
      end
    end
  endtask

  task automatic apply_pos();
    for (int i = 0; i < NS; i++) begin
      bus.snakepos_x[11*i +: 11] = 11'(sx[i]);
      bus.snakepos_y[11*i +: 11] = 11'(sy[i]);
    end
    bus.length     = 6'(len);
    bus.applepos_x = 11'(ax);
    bus.applepos_y = 11'(ay);
  endtask

  task automatic pulse(input int y);
    @(negedge clk);
    apply_pos();
    bus.next_y     = 11'(y);
    bus.line_start = 1'b1;
    p_y   = y;
    p_len = len;
    p_ay  = ay;
    p_sy  = sy;
    @(negedge clk);
    bus.line_start = 1'b0;
  endtask

  task automatic finish_scan(input string tag);
    int busy;
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.scan_busy) busy++;
      @(negedge clk);
    end
    chk(tag, busy, 24);
    act_ok  = 1'b1;
    act_y   = p_y;
    act_len = p_len;
    act_ay  = p_ay;
    act_sy  = p_sy;
  endtask

  task automatic line(input int y);
    pulse(y);
    finish_scan("scan_busy_len");
  endtask

  task automatic pix(input string tag, input int x, input bit de,
                     input bit ge);
    int es, ea;
    @(negedge clk);
    apply_pos();
    bus.curr_x   = 11'(x);
    bus.de       = de;
    bus.game_end = ge;
    model(x, de, ge, es, ea);
    @(negedge clk);
    obs_sel  = int'(bus.sel);
    obs_addr = int'(bus.sprite_addr);
    chk({tag, ".sel"}, obs_sel, es);
    chk({tag, ".addr"}, obs_addr, ea);
    chk({tag, ".vld"}, int'(bus.sel_valid), int'(de));
  endtask

  task automatic far_all();
    for (int i = 0; i < NS; i++) begin
      sx[i] = 1500;
      sy[i] = 1500;
    end
    ax = 1000;
    ay = 1000;
  endtask

  int bx0, by0;

  initial begin
    bus.line_start = 1'b0;
    bus.next_y     = '0;
    bus.de         = 1'b0;
    bus.curr_x     = '0;
    bus.game_end   = 1'b0;
    far_all();
    len = 1;
    apply_pos();

    // Reset with random inputs toggling
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.line_start = 1'($urandom);
      bus.next_y     = 11'($urandom);
      bus.de         = 1'($urandom);
      bus.curr_x     = 11'($urandom);
      bus.snakepos_x = {8{32'($urandom)}};
      bus.snakepos_y = {8{32'($urandom)}};
      @(posedge clk);
      #1;
      chk("rst.sel", int'(bus.sel), 0);
      chk("rst.vld", int'(bus.sel_valid), 0);
      chk("rst.addr", int'(bus.sprite_addr), 0);
      chk("rst.busy", int'(bus.scan_busy), 0);
    end
    @(negedge clk);
    bus.line_start = 1'b0;
    bus.de         = 1'b0;
    apply_pos();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle.busy", int'(bus.scan_busy), 0);
    end

    // Apple address
    far_all();
    ax = 100; ay = 200;
    sx[0] = 500; sy[0] = 500;
    len = 1;
    line(203);
    pix("apple", 105, 1'b1, 1'b0);
    chk("apple.sel_c", obs_sel, 1);
    chk("apple.addr_c", obs_addr, 101);

    // Priority and length gating
    far_all();
    ax = 64; ay = 64;
    sx[0] = 64; sy[0] = 64;
    len = 1;
    line(64);
    pix("prio", 64, 1'b1, 1'b0);
    chk("prio.sel_c", obs_sel, 1);
    ax = 1000; ay = 1000;
    sx[3] = 300; sy[3] = 64;
    len = 3;
    line(64);
    pix("len3", 300, 1'b1, 1'b0);
    chk("len3.sel_c", obs_sel, 0);
    len = 4;
    line(64);
    pix("len4", 300, 1'b1, 1'b0);
    chk("len4.sel_c", obs_sel, 3);
    chk("len4.addr_c", obs_addr, 0);

    // Sprite edges
    far_all();
    sx[0] = 32; sy[0] = 32;
    len = 1;
    line(63);
    pix("edge_in", 63, 1'b1, 1'b0);
    chk("edge_in.sel_c", obs_sel, 2);
    chk("edge_in.addr_c", obs_addr, 1023);
    pix("edge_out", 64, 1'b1, 1'b0);
    chk("edge_out.sel_c", obs_sel, 0);
    line(31);
    pix("edge_above", 40, 1'b1, 1'b0);
    chk("edge_above.sel_c", obs_sel, 0);

    // Restart mid-scan
    far_all();
    sx[0] = 500; sy[0] = 5;
    sx[1] = 600; sy[1] = 40;
    len = 2;
    pulse(10);
    for (int i = 0; i < 9; i++) @(negedge clk);
    pulse(40);
    finish_scan("restart.busy");
    pix("restart_head", 505, 1'b1, 1'b0);
    chk("restart_head.sel_c", obs_sel, 0);
    pix("restart_body", 605, 1'b1, 1'b0);
    chk("restart_body.sel_c", obs_sel, 3);
    chk("restart_body.addr_c", obs_addr, 5);

    // game_end and de gating
    far_all();
    ax = 100; ay = 200;
    len = 1;
    line(210);
    pix("ge", 110, 1'b1, 1'b1);
    chk("ge.sel_c", obs_sel, 0);
    chk("ge.addr_c", obs_addr, 0);
    pix("de0", 110, 1'b0, 1'b0);
    pix("ge_hit", 110, 1'b1, 1'b0);

    // Reset in mid-scan clears the active set
    pulse(210);
    for (int i = 0; i < 5; i++) @(negedge clk);
    rst = 1'b0;
    act_ok = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("rst_scan.busy", int'(bus.scan_busy), 0);
    pix("rst_scan", 110, 1'b1, 1'b0);
    chk("rst_scan.sel_c", obs_sel, 0);

    // Randomized clustered scenes, including wrap around 2047
    for (int l = 0; l < 25; l++) begin
      bx0 = (l % 4 == 0) ? 2030 : int'($urandom_range(0, 2047));
      by0 = (l % 4 == 1) ? 2040 : int'($urandom_range(0, 2047));
      for (int i = 0; i < NS; i++) begin
        sx[i] = md(bx0 + int'($urandom_range(0, 128)) - 64);
        sy[i] = md(by0 + int'($urandom_range(0, 80)) - 40);
      end
      ax  = md(bx0 + int'($urandom_range(0, 128)) - 64);
      ay  = md(by0 + int'($urandom_range(0, 80)) - 40);
      len = int'($urandom_range(0, 30));
      line(md(by0 + int'($urandom_range(0, 80)) - 40));
      for (int p = 0; p < 16; p++) begin
        pix("rnd", md(bx0 + int'($urandom_range(0, 160)) - 80),
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 15) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/render_scheduler.md
Name: render_scheduler

Overview:
- Pixel-rate controller that sequences the sprite-ROM datapath of the snake renderer.
- Per scanline, pre-scans apple, head and body-segment positions during horizontal blanking and builds a row-hit mask.
- Per active pixel, selects the winning layer (apple > head > body > grass) and issues the sprite-local ROM address.
- Sits between the VGA timing generator and the sprite ROMs/pixel mux.

Parameters:
MAX_SEGMENTS, 23, number of 11-bit position slots scanned (slot 0 = head)
BLK_SIZE, 32, sprite edge in pixels (power of two; address = ly*BLK_SIZE+lx)
ADDR_W, 10, sprite ROM address width (log2(BLK_SIZE^2))

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset
line_start  input  1  one-cycle pulse at start of hblank; next_y valid same cycle
next_y  input  11  y coordinate of the upcoming active line
de  input  1  active-video qualifier for curr_x
curr_x  input  11  current pixel x
snakepos_x  input  253  packed 11-bit x per slot, slot i at [11*i +: 11]
snakepos_y  input  253  packed 11-bit y per slot
length  input  6  live segment count including head
applepos_x  input  11  apple x
applepos_y  input  11  apple y
game_end  input  1  lose|win; suppresses all sprites
sel  output  2  layer for the issued address: 0 grass, 1 apple, 2 head, 3 body
sel_valid  output  1  registered de
sprite_addr  output  ADDR_W  sprite-local ROM address
scan_busy  output  1  high while the line pre-scan runs

Behaviour:
- Clocking: single clock. rst is synchronous and active-low.
- Reset (rst=0): state IDLE; shadow and active masks cleared; line_y=0. Outputs: sel=0, sel_valid=0, sprite_addr=0, scan_busy=0.
- FSM states: IDLE, SCAN, COMMIT.
- IDLE:
  - line_start latches next_y into line_y, sets idx=0, and moves to SCAN.
  - In the same cycle, computes apple_row = (line_y_new - applepos_y) < BLK_SIZE, using unsigned 11-bit subtraction, so y below the sprite top wraps and fails.
- SCAN:
  - One slot per cycle, idx = 0 .. MAX_SEGMENTS-1.
  - shadow_mask[idx] = (idx < length) && ((line_y - snakepos_y[idx]) < BLK_SIZE).
  - shadow_dy[idx] = low log2(BLK_SIZE) bits of that difference.
  - After idx = MAX_SEGMENTS-1, move to COMMIT.
- COMMIT: copy shadow mask, dy and apple_row/apple_dy to the active set, then go to IDLE.
- scan_busy = 1 in SCAN and COMMIT, i.e. MAX_SEGMENTS+1 cycles after the line_start cycle.
- line_start while in SCAN or COMMIT restarts the scan from idx=0 with the new next_y. The active set is not updated by an aborted scan.
- length > MAX_SEGMENTS: behaves as MAX_SEGMENTS. length = 0: no slots hit, head included.
- Per-pixel stage (every cycle, uses the active set only):
  - apple hit = apple_row && (curr_x - applepos_x) < BLK_SIZE.
  - head hit = mask[0] && (curr_x - snakepos_x[0]) < BLK_SIZE.
  - body hit on slot i = mask[i] && x test; the lowest hitting i ≥ 1 wins.
  - Priority: apple > head > body > grass.
  - sprite_addr = {dy_winner, dx_winner} with dx = curr_x - px truncated.
  - Grass: sprite_addr = 0.
  - game_end=1 or de=0 forces sel=0 and addr=0.
- Latency: sel, sprite_addr and sel_valid are registered 1 cycle after curr_x/de. The ROM data then returns 1 further cycle later, and the downstream mux delays sel by 1 to match.
- Boundaries:
  - x = px+BLK_SIZE-1 hits; px+BLK_SIZE misses.
  - Positions near 2047 wrap consistently under the modulo-2048 difference.
- Position inputs are sampled live during SCAN. Upstream holds them stable from line_start to COMMIT.
- Reset during SCAN returns to IDLE with both masks cleared.

Test Plan:
- Reset: hold rst=0 4 cycles with random inputs -> sel=0, sel_valid=0, sprite_addr=0, scan_busy=0. After release, scan_busy stays 0 until line_start.
- Apple address: apple (100,200), head (500,500), line_start next_y=203, wait 25 cycles, curr_x=105 with de=1 -> next cycle sel=1, sprite_addr=101, sel_valid=1. scan_busy is high exactly 24 cycles.
- Priority and length gating:
  - Apple and head both at (64,64), next_y=64, curr_x=64 -> sel=1.
  - Move apple away, length=3, slot 3 at (300,64), curr_x=300 -> sel=0.
  - Set length=4, curr_x=300 -> sel=3, addr=0.
- Edges: head at (32,32), next_y=63. curr_x=63 -> sel=2, addr=1023. curr_x=64 -> sel=0. next_y=31 with curr_x=40 -> sel=0.
- Restart mid-scan: line_start y=10, then line_start y=40 at scan cycle 10 -> scan_busy stays high 24 cycles from the second pulse. The active mask reflects y=40 only, and the y=10 mask is never committed.
- game_end: game_end=1 on an apple-hit pixel -> sel=0, addr=0. de=0 -> sel_valid=0 next cycle.
